gtech_mux_n_reg: RTL
====================

# gtech_mux_n_reg

Parametrised N-input, W-bit registered multiplexer with valid/ready handshakes and packet-atomic selection. It is the sequential successor to the GTECH 2:1 mux and sits between several streaming producers and a single consumer. Channel choice is either steered externally by `S` or made internally by round-robin arbitration. A grant is held from the first beat of a packet through its `LAST` beat.

## Interface
Parameters:
- `W`, 8: data width per channel; must be ≥1.
- `N`, 4: number of input channels; must be ≥1.
- `RR`, 0: selection mode. 0 = channel given by `S`; 1 = round-robin among valid channels.
- `SW`, derived localparam: `N>1 ? clog2(N) : 1`. Not overridable.

Ports:
- `CLK`, input, 1: rising-edge clock.
- `RST`, input, 1: asynchronous, active-high reset.
- `A_VALID`, input, N: per-channel valid.
- `A_DATA`, input, N*W: channel i occupies bits `[i*W +: W]`.
- `A_LAST`, input, N: per-channel end-of-packet flag.
- `A_READY`, output, N: per-channel ready.
- `S`, input, SW: channel select. Used only when `RR=0`.
- `Z_VALID`, output, 1: output valid.
- `Z_DATA`, output, W: output data.
- `Z_LAST`, output, 1: output end-of-packet flag.
- `Z_READY`, input, 1: consumer ready.

## Operation
- Internal state:
  - `locked` (1 bit).
  - `gsel` (SW bits): granted channel.
  - `ptr` (SW bits): last channel to complete a packet. Used only when `RR=1`.
- Load enable: `ld = !Z_VALID || Z_READY`. The output register is a single stage, so full throughput is one beat per cycle.
- Candidate channel `c`:
  - If `locked`, `c = gsel`.
  - Otherwise, `RR=0`: `c = S`. If `S >= N`, there is no candidate.
  - Otherwise, `RR=1`: `c` is the first i with `A_VALID[i]=1`, searching cyclically from `ptr+1` (wrap N-1→0). If no channel is valid, there is no candidate.
- `A_READY[i] = ld && candidate exists && i == c && !RST`. All other ready bits are 0. Ready may depend on `A_VALID` in RR mode. Valid must never depend on ready.
- Transfer: `xfer = A_VALID[c] && A_READY[c]`.
- On each clock edge when `ld=1`:
  - `Z_VALID <= xfer`.
  - If `xfer`: `Z_DATA <= A_DATA[c]` and `Z_LAST <= A_LAST[c]`.
  - If not `xfer`: `Z_DATA` and `Z_LAST` hold.
- When `ld=0`, all Z outputs hold (stall).
- Lock update on `xfer`:
  - `A_LAST[c]=0`: `locked <= 1`, `gsel <= c`.
  - `A_LAST[c]=1`: `locked <= 0`, `ptr <= c`.
- No `xfer` leaves `locked`, `gsel` and `ptr` unchanged.
- While `locked`:
  - Changes on `S` are ignored.
  - Other channels' `A_VALID` is ignored.
  - Deassertion of `A_VALID[gsel]` stalls the packet without releasing the grant.
- Single-beat packets (`LAST` on the first beat) never set `locked`.
- `N=1`: `c` is always 0 and `S` is ignored.

## Timing
- Reset values, applied asynchronously:
  - `Z_VALID=0`, `Z_DATA=0`, `Z_LAST=0`.
  - `locked=0`, `gsel=0`, `ptr=N-1`, so channel 0 has first RR priority.
  - All `A_READY=0` while `RST=1`.
- Reset mid-packet: the lock is dropped and any pending Z beat is discarded. The first post-reset packet is arbitrated fresh.
- Latency: an input beat accepted at edge k is presented on Z in the cycle following edge k.
- Back-to-back packets: the first beat of the next packet can transfer in the cycle immediately after the `LAST` transfer. There is no dead cycle.
- RR fairness: with all N channels continuously valid and sending single-beat packets, the grant order is 0,1,…,N-1,0,…, one channel per cycle when `Z_READY=1`.
- Backpressure: with `Z_VALID=1` and `Z_READY=0`, all `A_READY=0` and Z is stable.
- Simultaneous `Z_READY=1` and a new `xfer` in one cycle: the Z register is replaced with the new beat, giving full throughput.

## Test plan
- **Reset:** assert `RST` mid-stream with `Z_VALID=1` and `locked=1` → immediately `Z_VALID=0`, `Z_DATA=0`, all `A_READY=0`. After release, `RR=1` with all channels valid grants channel 0 first.
- **RR=0 steering, N=4, W=8:** `S=2`, channel 2 sends a 3-beat packet 0x11,0x22,0x33 with LAST on 0x33. `S` changes to 1 after the first beat → Z carries 0x11,0x22,0x33 on consecutive cycles, `Z_LAST` only on 0x33. Channel 1 is then granted on the next cycle.
- **RR=1 fairness, N=4:** all channels valid, single-beat packets carrying data=channel index, `Z_READY=1` → Z_DATA sequence 0,1,2,3,0,1,…, one beat per cycle.
- **Backpressure:** hold `Z_READY=0` for 5 cycles with a beat pending → Z_DATA stable, `A_READY=0` throughout. Release → the next beat appears on the cycle after release, with no loss or duplication.
- **Out-of-range and gaps:** `RR=0`, N=3, `S=3` → `A_READY` all 0 and `Z_VALID` stays 0. With a lock held on channel 1, deassert `A_VALID[1]` for 2 cycles while channel 0 is valid → channel 0 is never granted until channel 1 transfers LAST.
- **N=1 degenerate:** `S` driven with arbitrary values, 4-beat packet → all beats pass with 1-cycle latency.

Source files
------------

// File: rtl/gtech_mux_n_reg.sv
// gtech_mux_n_reg: N-input registered stream mux with packet-atomic S-steered or round-robin selection
module gtech_mux_n_reg #(
  parameter int W = 8,
  parameter int N = 4,
  parameter int RR = 0,
  localparam int SW = N > 1 ? $clog2(N) : 1
) (
  input  logic           CLK,
  input  logic           RST,
  input  logic [N-1:0]   A_VALID,
  input  logic [N*W-1:0] A_DATA,
  input  logic [N-1:0]   A_LAST,
  output logic [N-1:0]   A_READY,
  input  logic [SW-1:0]  S,
  output logic           Z_VALID,
  output logic [W-1:0]   Z_DATA,
  output logic           Z_LAST,
  input  logic           Z_READY
);
  logic ld, has_c, xfer, locked, sel_last;
  logic [SW-1:0] c, gsel, ptr;
  logic [W-1:0] sel_data;
  int d, best;
  assign ld = !Z_VALID || Z_READY;
  assign A_READY = (ld && has_c && !RST) ? (N'(1) << c) : '0;
  assign xfer = |(A_VALID & A_READY);
  // candidate: held grant, else S, else first valid channel cyclically after ptr
  always_comb begin
    c = gsel;
    has_c = 1'b1;
    d = 0;
    best = N;
    if (N == 1) c = '0;
    else if (!locked && RR == 0) begin
      c = S;
      has_c = int'(S) < N;
    end else if (!locked) begin
      c = '0;
      for (int i = 0; i < N; i++) begin
        d = (i + N - 1 - int'(ptr)) % N;
        if (A_VALID[i] && d < best) begin
          best = d;
          c = SW'(i);
        end
      end
      has_c = best < N;
    end
  end
  // route the candidate's data and last flag
  always_comb begin
    sel_data = '0;
    sel_last = 1'b0;
    for (int i = 0; i < N; i++)
      if (SW'(i) == c) begin
        sel_data = A_DATA[i*W +: W];
        sel_last = A_LAST[i];
      end
  end
  // output register and grant state; reset drops any lock and pending beat
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      Z_VALID <= 1'b0;
      Z_DATA <= '0;
      Z_LAST <= 1'b0;
      locked <= 1'b0;
      gsel <= '0;
      ptr <= SW'(N - 1);
    end else begin
      if (ld) Z_VALID <= xfer;
      if (xfer) begin
        Z_DATA <= sel_data;
        Z_LAST <= sel_last;
        locked <= !sel_last;
        if (sel_last) ptr <= c;
        else gsel <= c;
      end
    end
endmodule
